// File: rtl/channel_pkg.sv
// ============================================================================
// channel_pkg : shared constants and types for the error-injection channel
// Revision    : 1.0
// ============================================================================
`default_nettype none

package channel_pkg;

  // Hamming(11,7) codeword: parity at bits 0,1,3,7; data at 10:8, 6:4, 2
  localparam int CW_WIDTH = 11;
  localparam int PARITY_POS [4] = '{0, 1, 3, 7};

  localparam int LFSR_WIDTH = 16;
  // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_RAND1 = 2'b01,
    ERR_FIXED = 2'b10,
    ERR_RAND2 = 2'b11
  } err_mode_e;

  // Single-subtraction modulo; callers guarantee v < 2*lim
  function automatic logic [4:0] fold(input logic [4:0] v, input logic [4:0] lim);
    return (v < lim) ? v : v - lim;
  endfunction

endpackage

`default_nettype wire

// File: rtl/channel_if.sv
// ============================================================================
// channel_if : word stream, error controls and status of the channel
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface channel_if
  import channel_pkg::*;
#(
  parameter int WIDTH = CW_WIDTH
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             err_en;
  logic [1:0]       err_mode;
  logic [3:0]       err_pos;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [WIDTH-1:0] err_mask;
  logic [15:0]      err_count;

  // master drives words and error controls; slave is the channel itself
  modport master (
    output din, din_valid, err_en, err_mode, err_pos,
    input  dout, dout_valid, err_mask, err_count
  );

  modport slave (
    input  din, din_valid, err_en, err_mode, err_pos,
    output dout, dout_valid, err_mask, err_count
  );
endinterface

`default_nettype wire

// File: rtl/channel_lfsr.sv
// ============================================================================
// channel_lfsr : 16-bit Fibonacci LFSR, shift left, advances only when adv=1
// Revision     : 1.0
// ============================================================================
`default_nettype none

module channel_lfsr
  import channel_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] SEED = 16'hACE1  // must be nonzero
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  adv,
  output logic      [LFSR_WIDTH-1:0] lfsr
);

  logic [LFSR_WIDTH-1:0] r_state;
  logic                  w_fb;

  assign w_fb = ^(r_state & LFSR_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else if (adv) begin
      r_state <= {r_state[LFSR_WIDTH-2:0], w_fb};
    end
  end

  assign lfsr = r_state;

endmodule

`default_nettype wire

// File: rtl/channel.sv
// ============================================================================
// channel : 1-cycle codeword channel with LFSR-driven bit-error injection
// Revision: 1.0
// ============================================================================
`default_nettype none

module channel
  import channel_pkg::*;
#(
  parameter int                    WIDTH     = CW_WIDTH,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1
) (
  input  wire logic clk,
  input  wire logic rst_n,
  channel_if.slave  bus
);

  localparam logic [4:0]       c_npos = 5'(CW_WIDTH);
  localparam logic [4:0]       c_nk   = 5'(CW_WIDTH - 1);
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

  logic [LFSR_WIDTH-1:0] w_lfsr;
  logic                  w_unused_lfsr;
  logic [4:0]            w_p1;
  logic [4:0]            w_k;
  logic [4:0]            w_p2;
  logic [WIDTH-1:0]      w_mask;
  logic [4:0]            w_pop;
  logic [16:0]           w_sum;
  logic [15:0]           w_count_nxt;

  logic [WIDTH-1:0]      r_dout;
  logic                  r_dout_valid;
  logic [WIDTH-1:0]      r_mask;
  logic [15:0]           r_count;

  channel_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (bus.din_valid),
    .lfsr  (w_lfsr)
  );

  // Positions use the pre-advance LFSR value; p2 is offset 1..10 from p1
  // modulo 11, so it can never land on p1.
  assign w_p1          = fold({1'b0, w_lfsr[3:0]}, c_npos);
  assign w_k           = fold({1'b0, w_lfsr[7:4]}, c_nk);
  assign w_p2          = fold(w_p1 + w_k + 5'd1, c_npos);
  assign w_unused_lfsr = ^w_lfsr[LFSR_WIDTH-1:8];

  always_comb begin
    w_mask = '0;
    if (bus.err_en) begin
      case (err_mode_e'(bus.err_mode))
        ERR_RAND1: w_mask = c_one << w_p1;
        ERR_FIXED: begin
          if ({1'b0, bus.err_pos} < c_npos) begin
            w_mask = c_one << bus.err_pos;
          end
        end
        ERR_RAND2: w_mask = (c_one << w_p1) | (c_one << w_p2);
        default:   w_mask = '0;
      endcase
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + {4'd0, w_mask[i]};
    end
  end

  assign w_sum       = {1'b0, r_count} + {12'd0, w_pop};
  assign w_count_nxt = w_sum[16] ? 16'hFFFF : w_sum[15:0];

  // Idle cycles only clear dout_valid; data, mask and count hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_mask       <= '0;
      r_count      <= '0;
    end else begin
      r_dout_valid <= bus.din_valid;
      if (bus.din_valid) begin
        r_dout  <= bus.din ^ w_mask;
        r_mask  <= w_mask;
        r_count <= w_count_nxt;
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.err_mask   = r_mask;
  assign bus.err_count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_channel.sv
// ============================================================================
// tb_channel : randomized self-checking bench for channel against a
//              behavioural model (modulo arithmetic, polynomial LFSR)
// ============================================================================
`default_nettype none

module tb_channel;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  channel_if #(.WIDTH(11)) bus ();

  channel #(
    .WIDTH     (11),
    .LFSR_SEED (SEED)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  string phase    = "init";

  logic [15:0] m_lfsr;
  logic [10:0] m_dout;
  logic [10:0] m_mask;
  logic        m_valid;
  logic [15:0] m_count;
  logic [10:0] ref_seq [20];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic logic [10:0] model_mask(input logic [15:0] s, input logic en,
                                             input logic [1:0] mode, input logic [3:0] pos);
    int p1, k, p2;
    logic [10:0] one;
    one = 11'd1;
    p1  = int'(s[3:0]) % 11;
    k   = int'(s[7:4]) % 10;
    p2  = (p1 + 1 + k) % 11;
    if (!en) return '0;
    case (mode)
      2'b01:   return one << p1;
      2'b10:   return (pos < 4'd11) ? (one << pos) : 11'd0;
      2'b11:   return (one << p1) | (one << p2);
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_lfsr  = SEED;
    m_dout  = '0;
    m_mask  = '0;
    m_valid = 1'b0;
    m_count = '0;
  endtask

  task automatic step(input logic [10:0] d, input logic v, input logic en,
                      input logic [1:0] mode, input logic [3:0] pos);
    logic [10:0] mk;
    int          sum;
    bus.din       = d;
    bus.din_valid = v;
    bus.err_en    = en;
    bus.err_mode  = mode;
    bus.err_pos   = pos;
    @(posedge clk);
    #1;
    m_valid = v;
    if (v) begin
      mk      = model_mask(m_lfsr, en, mode, pos);
      m_lfsr  = lfsr_next(m_lfsr);
      m_mask  = mk;
      m_dout  = d ^ mk;
      sum     = int'(m_count) + $countones(mk);
      m_count = (sum > 65535) ? 16'hFFFF : 16'(sum);
    end
    check({phase, "_valid"}, 32'(bus.dout_valid), 32'(m_valid));
    check({phase, "_dout"},  32'(bus.dout),       32'(m_dout));
    check({phase, "_mask"},  32'(bus.err_mask),   32'(m_mask));
    check({phase, "_count"}, 32'(bus.err_count),  32'(m_count));
  endtask

  // Reset asserted and released between clock edges; outputs must clear at once
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check({phase, "_rst_dout"},  32'(bus.dout),       32'd0);
    check({phase, "_rst_valid"}, 32'(bus.dout_valid), 32'd0);
    check({phase, "_rst_mask"},  32'(bus.err_mask),   32'd0);
    check({phase, "_rst_count"}, 32'(bus.err_count),  32'd0);
    bus.din_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [15:0] s;
    logic [10:0] d;
    logic [10:0] hits;

    rst_n         = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.err_en    = 1'b0;
    bus.err_mode  = 2'b00;
    bus.err_pos   = 4'd0;
    model_reset();

    s = SEED;
    for (int i = 0; i < 20; i++) begin
      ref_seq[i] = model_mask(s, 1'b1, 2'b11, 4'd0);
      s          = lfsr_next(s);
    end

    repeat (2) @(posedge clk);
    #1;
    phase = "reset";
    check("reset_dout",  32'(bus.dout),       32'd0);
    check("reset_valid", 32'(bus.dout_valid), 32'd0);
    check("reset_mask",  32'(bus.err_mask),   32'd0);
    check("reset_count", 32'(bus.err_count),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Transparent channel even with a random mode selected
    phase = "transp";
    step(11'h5A5, 1'b1, 1'b0, 2'b11, 4'd0);
    check("transp_dout_exp",  32'(bus.dout),       32'h5A5);
    check("transp_valid_exp", 32'(bus.dout_valid), 32'd1);
    check("transp_mask_exp",  32'(bus.err_mask),   32'd0);
    check("transp_count_exp", 32'(bus.err_count),  32'd0);

    phase = "fixed";
    step(11'h000, 1'b1, 1'b1, 2'b10, 4'd7);
    check("fixed7_dout_exp",  32'(bus.dout),      32'h080);
    check("fixed7_mask_exp",  32'(bus.err_mask),  32'h080);
    check("fixed7_count_exp", 32'(bus.err_count), 32'd1);
    d = 11'($urandom);
    step(d, 1'b1, 1'b1, 2'b10, 4'd12);
    check("fixed12_dout_exp",  32'(bus.dout),      32'(d));
    check("fixed12_count_exp", 32'(bus.err_count), 32'd1);
    step(11'($urandom), 1'b1, 1'b1, 2'b10, 4'd10);
    step(11'($urandom), 1'b1, 1'b1, 2'b10, 4'd11);
    step(11'($urandom), 1'b1, 1'b1, 2'b10, 4'd15);
    step(11'($urandom), 1'b1, 1'b1, 2'b00, 4'd3);
    step(11'($urandom), 1'b0, 1'b1, 2'b01, 4'd3);

    phase = "rand1";
    do_reset();
    hits = '0;
    for (int i = 0; i < 1000; i++) begin
      d = 11'($urandom);
      step(d, 1'b1, 1'b1, 2'b01, 4'($urandom));
      check("rand1_pop", 32'($countones(bus.dout ^ d)), 32'd1);
      hits = hits | bus.err_mask;
    end
    check("rand1_hits",  32'(hits),          32'h7FF);
    check("rand1_total", 32'(bus.err_count), 32'd1000);

    phase = "rand2";
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      step(11'($urandom), 1'b1, 1'b1, 2'b11, 4'($urandom));
      if (i == 0) check("rand2_first_mask", 32'(bus.err_mask), 32'h042);
      check("rand2_pop", 32'($countones(bus.err_mask)), 32'd2);
    end
    check("rand2_total", 32'(bus.err_count), 32'd2000);

    // Idle gaps must not disturb the random sequence
    phase = "gap";
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(11'($urandom), 1'b1, 1'b1, 2'b11, 4'($urandom));
      check("gap_seq", 32'(bus.err_mask), 32'(ref_seq[i]));
      repeat (5) step(11'($urandom), 1'b0, 1'($urandom), 2'($urandom), 4'($urandom));
    end

    phase = "mix";
    for (int i = 0; i < 300; i++) begin
      step(11'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
           2'($urandom), 4'($urandom));
    end

    // Mid-stream reset with a word in flight, then replay the seed sequence
    phase = "midrst";
    step(11'($urandom), 1'b1, 1'b1, 2'b11, 4'd0);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(11'($urandom), 1'b1, 1'b1, 2'b11, 4'($urandom));
      check("midrst_seq", 32'(bus.err_mask), 32'(ref_seq[i]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/channel.md
CHANNEL -- requirements
Module: channel

Interface
REQ-001 Parameter WIDTH, default 11: codeword width; Hamming(11,7), parity at bits 0,1,3,7, data at bits 10:8,6:4,2.
REQ-002 Parameter LFSR_SEED, default 16'hACE1: LFSR value loaded at reset; SHALL be nonzero.
REQ-003 Clocking/reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 din  input  WIDTH  transmitted codeword.
REQ-007 din_valid  input  1  din accepted on this clock edge when high.
REQ-008 err_en  input  1  error injection enable; when low, the channel is transparent.
REQ-009 err_mode  input  2  00 none, 01 random single-bit, 10 fixed single-bit, 11 random double-bit.
REQ-010 err_pos  input  4  flip position for mode 10.
REQ-011 dout  output  WIDTH  received (possibly corrupted) codeword.
REQ-012 dout_valid  output  1  dout holds a new word.
REQ-013 err_mask  output  WIDTH  bits flipped in the current dout (dout = din XOR err_mask).
REQ-014 err_count  output  16  total bits flipped since reset, saturating.

Function
REQ-015 Latency: exactly 1 cycle; a word accepted at edge N SHALL appear on dout with dout_valid=1 after edge N.
REQ-016 Cycle without din_valid: dout_valid SHALL drop to 0; dout and err_mask SHALL hold their values; the LFSR and err_count SHALL not change.
REQ-017 LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0; SHALL advance once per accepted word only.
REQ-018 Random positions SHALL use the LFSR value before the advance: v1=lfsr[3:0], p1 = v1 if v1<11 else v1-11.
REQ-019 Second position: v2=lfsr[7:4], k = v2 if v2<10 else v2-10, p2 = (p1+1+k) mod 11; p2 SHALL never equal p1.
REQ-020 Mask: err_en=0 or mode 00 -> zero; 01 -> one-hot p1; 10 -> one-hot err_pos if err_pos<11, else zero; 11 -> one-hot p1 OR one-hot p2.
REQ-021 Registered outputs: dout = din XOR mask; err_mask = mask.
REQ-022 err_count SHALL add popcount(mask) (0,1 or 2) per accepted word and saturate at 16'hFFFF.
REQ-023 err_en, err_mode and err_pos SHALL be sampled on the same edge as din; changes take effect on the next accepted word.

Reset
REQ-024 While rst_n=0: dout=0, dout_valid=0, err_mask=0, err_count=0, lfsr=LFSR_SEED, independent of clk.
REQ-025 Reset applied mid-stream SHALL discard the in-flight word; the first word after rst_n rises SHALL use LFSR_SEED.

Structure
REQ-026 Shared package SHALL hold the err_mode encodings (ERR_NONE, ERR_RAND1, ERR_FIXED, ERR_RAND2), codeword width 11, parity positions {0,1,3,7} and the LFSR tap constant.
REQ-027 One sub-module, channel_lfsr (16-bit, seed parameter, advance enable, async reset), SHALL hold the LFSR; all other logic stays in channel.

Verification
REQ-028 err_en=0, din=11'h5A5 with din_valid=1 -> after 1 cycle dout=11'h5A5, dout_valid=1, err_mask=0, err_count=0.
REQ-029 Mode 10, err_pos=7, din=11'h000 -> dout=11'h080, err_mask=11'h080, err_count=1; err_pos=12 -> dout=din, count unchanged.
REQ-030 Mode 01, 1000 random words -> popcount(din XOR dout)=1 every word, err_mask matches, all 11 positions hit, err_count=1000.
REQ-031 Mode 11, 1000 words -> popcount(err_mask)=2 every word, err_count=2000; first word after reset with seed 16'hACE1 gives p1=1, p2=6, err_mask=11'h042.
REQ-032 din_valid held low 5 cycles between words -> dout_valid=0, dout, err_mask and LFSR held; the random sequence is identical to a gap-free run.
REQ-033 rst_n pulsed low asynchronously, between clock edges, mid-stream -> outputs zero immediately; the post-reset mask sequence repeats the first post-reset sequence.
